// File: rtl/divchk_pkg.sv
// Shared types and defaults for the divided-clock checker.
// Holds the channel FSM encoding, default parameters and a bound helper.
package divchk_pkg;

  typedef enum logic [1:0] {
    IDLE,
    MEASURE,
    LOCKED,
    ERROR
  } chk_state_t;

  localparam int DEF_EXP_P_10K  = 100;
  localparam int DEF_EXP_P_100K = 10;
  localparam int DEF_TOL        = 0;
  localparam int DEF_LOCK_COUNT = 4;
  localparam int DEF_CNT_W      = 8;

  // Lower acceptance bound, clamped so a large tolerance cannot wrap.
  function automatic int lo_bound(int v, int t);
    return (v > t) ? v - t : 0;
  endfunction

endpackage

// File: rtl/divchk_channel.sv
// One checker channel: sync + edge detect, period/high counters, lock FSM.
// Ports: clk/rst (async high), clear, clk_in (async data), locked/err/period.
module divchk_channel
  import divchk_pkg::*;
#(
  parameter int EXP_P      = DEF_EXP_P_100K,
  parameter int TOL        = DEF_TOL,
  parameter int LOCK_COUNT = DEF_LOCK_COUNT,
  parameter int CNT_W      = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             clk_in,
  output logic             locked,
  output logic             err,
  output logic [CNT_W-1:0] period
);

  localparam int GW   = $clog2(LOCK_COUNT + 1);
  localparam int HEXP = EXP_P / 2;

  localparam logic [CNT_W-1:0] P_MIN = CNT_W'(lo_bound(EXP_P, TOL));
  localparam logic [CNT_W-1:0] P_MAX = CNT_W'(EXP_P + TOL);
  localparam logic [CNT_W-1:0] H_MIN = CNT_W'(lo_bound(HEXP, TOL));
  localparam logic [CNT_W-1:0] H_MAX = CNT_W'(HEXP + TOL);
  localparam logic [CNT_W-1:0] T_OUT = CNT_W'(EXP_P + TOL + 1);
  localparam logic [GW-1:0]    G_LAST = GW'(LOCK_COUNT - 1);

  logic s1_q, s2_q, s3_q;
  logic [CNT_W-1:0] pcnt_q, pcnt_d;
  logic [CNT_W-1:0] hcnt_q, hcnt_d;
  logic [CNT_W-1:0] high_q, high_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic [GW-1:0]    good_q, good_d;
  logic             locked_q, locked_d;
  logic             err_q, err_d;
  chk_state_t       state_q, state_d;

  logic rise, fall;
  logic good_per, timeout, bad;
  logic [CNT_W-1:0] pcnt_inc, hcnt_inc;

  always_comb begin
    rise = s2_q & ~s3_q;
    fall = ~s2_q & s3_q;
    pcnt_inc = (&pcnt_q) ? pcnt_q : pcnt_q + CNT_W'(1);
    hcnt_inc = (&hcnt_q) ? hcnt_q : hcnt_q + CNT_W'(1);
    good_per = (pcnt_q >= P_MIN) && (pcnt_q <= P_MAX) &&
               (high_q >= H_MIN) && (high_q <= H_MAX);
    // Equality fires once; pcnt then runs on towards saturation.
    timeout = ~rise & (pcnt_q == T_OUT);
    bad = (rise & ~good_per) | timeout;
  end

  always_comb begin
    pcnt_d   = pcnt_q;
    period_d = period_q;
    hcnt_d   = hcnt_q;
    high_d   = high_q;
    if (clear) begin
      pcnt_d = '0;
    end else if (rise) begin
      pcnt_d   = CNT_W'(1);
      period_d = pcnt_q;
    end else begin
      pcnt_d = pcnt_inc;
    end
    if (rise)
      hcnt_d = CNT_W'(1);
    else if (s2_q)
      hcnt_d = hcnt_inc;
    if (fall)
      high_d = hcnt_q;
  end

  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE:    if (rise) state_d = MEASURE;
        MEASURE: if (rise && good_per && good_q == G_LAST)
                   state_d = LOCKED;
        LOCKED:  if (bad) state_d = ERROR;
        ERROR:   state_d = ERROR;
      endcase
    end
  end

  always_comb begin
    good_d = good_q;
    err_d  = err_q;
    if (clear) begin
      good_d = '0;
      err_d  = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: if (rise) good_d = '0;
        MEASURE: begin
          if (rise && good_per)
            good_d = good_q + GW'(1);
          else if (bad)
            good_d = '0;
        end
        LOCKED: if (bad) err_d = 1'b1;
        ERROR: err_d = 1'b1;
      endcase
    end
    locked_d = (state_d == LOCKED);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      s3_q     <= 1'b0;
      pcnt_q   <= '0;
      hcnt_q   <= '0;
      high_q   <= '0;
      period_q <= '0;
      good_q   <= '0;
      locked_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      s1_q     <= clk_in;
      s2_q     <= s1_q;
      s3_q     <= s2_q;
      pcnt_q   <= pcnt_d;
      hcnt_q   <= hcnt_d;
      high_q   <= high_d;
      period_q <= period_d;
      good_q   <= good_d;
      locked_q <= locked_d;
      err_q    <= err_d;
    end
  end

  assign locked = locked_q;
  assign err    = err_q;
  assign period = period_q;

endmodule

// File: rtl/divider_checker.sv
// Monitors the 10 kHz and 100 kHz divider outputs in the clock1M domain.
// Ports: clock1M, reset, clear, two clocks under test; per-channel lock/err/period.
module divider_checker
  import divchk_pkg::*;
#(
  parameter int EXP_P_10K  = DEF_EXP_P_10K,
  parameter int EXP_P_100K = DEF_EXP_P_100K,
  parameter int TOL        = DEF_TOL,
  parameter int LOCK_COUNT = DEF_LOCK_COUNT,
  parameter int CNT_W      = DEF_CNT_W
) (
  input  logic             clock1M,
  input  logic             reset,
  input  logic             clear,
  input  logic             clk_10KHz,
  input  logic             clk_100KHz,
  output logic             locked_10KHz,
  output logic             locked_100KHz,
  output logic             err_10KHz,
  output logic             err_100KHz,
  output logic [CNT_W-1:0] period_10KHz,
  output logic [CNT_W-1:0] period_100KHz
);

  divchk_channel #(
    .EXP_P      (EXP_P_10K),
    .TOL        (TOL),
    .LOCK_COUNT (LOCK_COUNT),
    .CNT_W      (CNT_W)
  ) u_ch_10k (
    .clk    (clock1M),
    .rst    (reset),
    .clear  (clear),
    .clk_in (clk_10KHz),
    .locked (locked_10KHz),
    .err    (err_10KHz),
    .period (period_10KHz)
  );

  divchk_channel #(
    .EXP_P      (EXP_P_100K),
    .TOL        (TOL),
    .LOCK_COUNT (LOCK_COUNT),
    .CNT_W      (CNT_W)
  ) u_ch_100k (
    .clk    (clock1M),
    .rst    (reset),
    .clear  (clear),
    .clk_in (clk_100KHz),
    .locked (locked_100KHz),
    .err    (err_100KHz),
    .period (period_100KHz)
  );

endmodule

// File: tb/tb_divider_checker.sv
// Randomized bench for divider_checker: two DUTs (TOL 0 and 1) on shared inputs.
// Expected outputs come from a timestamp-based reference model.
`timescale 1ns/1ps
module tb_divider_checker;

  localparam int CW = 8;
  localparam int S_IDLE = 0;
  localparam int S_MEAS = 1;
  localparam int S_LOCK = 2;
  localparam int S_ERR  = 3;

  logic clock1M = 1'b0;
  logic reset = 1'b1;
  logic clear = 1'b0;
  logic clk_10KHz = 1'b0;
  logic clk_100KHz = 1'b0;
  logic [1:0] lk10, lk100, er10, er100;
  logic [1:0][CW-1:0] pd10, pd100;

  int checks = 0;
  int errors = 0;

  divider_checker u_dut0 (
    .clock1M (clock1M), .reset (reset), .clear (clear),
    .clk_10KHz (clk_10KHz), .clk_100KHz (clk_100KHz),
    .locked_10KHz (lk10[0]), .locked_100KHz (lk100[0]),
    .err_10KHz (er10[0]), .err_100KHz (er100[0]),
    .period_10KHz (pd10[0]), .period_100KHz (pd100[0])
  );

  divider_checker #(.TOL(1)) u_dut1 (
    .clock1M (clock1M), .reset (reset), .clear (clear),
    .clk_10KHz (clk_10KHz), .clk_100KHz (clk_100KHz),
    .locked_10KHz (lk10[1]), .locked_100KHz (lk100[1]),
    .err_10KHz (er10[1]), .err_100KHz (er100[1]),
    .period_10KHz (pd10[1]), .period_100KHz (pd100[1])
  );

  always #500 clock1M = ~clock1M;

  // channel 0 = 10 kHz, channel 1 = 100 kHz; instance i has tolerance i
  int exp_p [2] = '{100, 10};
  int tol_v [2] = '{0, 1};

  // reference model: time stamps of events, measured in clock1M edges
  bit m_hist [2][3];
  int m_n;
  int m_lrp [2];
  int m_lrh [2];
  int m_hm [2];
  int m_per [2];
  int m_st [2][2];
  int m_gc [2][2];
  bit m_err [2][2];

  // stimulus generator state
  bit g_lvl [2];
  int g_rem [2];
  int g_hi [2];
  int g_lo [2];
  int g_jit [2];
  int g_once [2];
  bit g_stuck [2];

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d", tag, obs, exp);
    end
  endtask

  function automatic int sat(input int v);
    return (v > 255) ? 255 : v;
  endfunction

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  task automatic model_reset();
    m_n = 0;
    for (int c = 0; c < 2; c++) begin
      for (int k = 0; k < 3; k++) m_hist[c][k] = 1'b0;
      m_lrp[c] = 1;
      m_lrh[c] = 0;
      m_hm[c]  = 0;
      m_per[c] = 0;
      for (int i = 0; i < 2; i++) begin
        m_st[i][c]  = S_IDLE;
        m_gc[i][c]  = 0;
        m_err[i][c] = 1'b0;
      end
    end
  endtask

  task automatic model_edge(input bit in10, input bit in100, input bit clr);
    bit inb [2];
    bit rise, fall, ok, tout, bad;
    int mp, mh, e, t;
    inb[0] = in10;
    inb[1] = in100;
    m_n++;
    for (int c = 0; c < 2; c++) begin
      rise = m_hist[c][1] && !m_hist[c][2];
      fall = !m_hist[c][1] && m_hist[c][2];
      mp = sat(m_n - m_lrp[c]);
      mh = sat(m_n - m_lrh[c]);
      for (int i = 0; i < 2; i++) begin
        e = exp_p[c];
        t = tol_v[i];
        ok = (iabs(mp - e) <= t) && (iabs(m_hm[c] - e / 2) <= t);
        tout = !rise && (mp == e + t + 1);
        bad = (rise && !ok) || tout;
        if (clr) begin
          m_st[i][c] = S_IDLE;
          m_gc[i][c] = 0;
          m_err[i][c] = 1'b0;
        end else begin
          case (m_st[i][c])
            S_IDLE: if (rise) begin
              m_st[i][c] = S_MEAS;
              m_gc[i][c] = 0;
            end
            S_MEAS: begin
              if (rise && ok) begin
                m_gc[i][c]++;
                if (m_gc[i][c] == 4) m_st[i][c] = S_LOCK;
              end else if (bad) begin
                m_gc[i][c] = 0;
              end
            end
            S_LOCK: if (bad) begin
              m_st[i][c] = S_ERR;
              m_err[i][c] = 1'b1;
            end
            default: ;
          endcase
        end
      end
      if (fall) m_hm[c] = mh;
      if (rise) m_lrh[c] = m_n;
      if (clr) m_lrp[c] = m_n + 1;
      else if (rise) begin
        m_per[c] = mp;
        m_lrp[c] = m_n;
      end
      m_hist[c][2] = m_hist[c][1];
      m_hist[c][1] = m_hist[c][0];
      m_hist[c][0] = inb[c];
    end
  endtask

  task automatic gen_tick();
    int len;
    for (int c = 0; c < 2; c++) begin
      if (g_stuck[c]) begin
        g_lvl[c] = 1'b0;
        g_rem[c] = 0;
      end else begin
        if (g_rem[c] <= 0) begin
          g_lvl[c] = !g_lvl[c];
          len = g_lvl[c] ? g_hi[c] : g_lo[c];
          if (!g_lvl[c] && g_once[c] > 0) begin
            len = g_once[c];
            g_once[c] = 0;
          end
          if (g_jit[c] > 0)
            len += int'($urandom_range(2 * g_jit[c])) - g_jit[c];
          if (len < 1) len = 1;
          g_rem[c] = len;
        end
        g_rem[c]--;
      end
    end
    clk_10KHz  = g_lvl[0];
    clk_100KHz = g_lvl[1];
  endtask

  task automatic compare_all();
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("u%0d_lk10", i), lk10[i], m_st[i][0] == S_LOCK);
      chk($sformatf("u%0d_lk100", i), lk100[i], m_st[i][1] == S_LOCK);
      chk($sformatf("u%0d_er10", i), er10[i], m_err[i][0]);
      chk($sformatf("u%0d_er100", i), er100[i], m_err[i][1]);
      chk($sformatf("u%0d_pd10", i), pd10[i], m_per[0]);
      chk($sformatf("u%0d_pd100", i), pd100[i], m_per[1]);
    end
  endtask

  task automatic step(input bit clr);
    @(negedge clock1M);
    gen_tick();
    clear = clr;
    @(posedge clock1M);
    if (!reset) model_edge(clk_10KHz, clk_100KHz, clr);
    #1;
    compare_all();
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) step(1'b0);
  endtask

  task automatic set_ideal();
    g_hi = '{50, 5};
    g_lo = '{50, 5};
    g_jit = '{0, 0};
  endtask

  initial begin
    bit found;
    model_reset();
    set_ideal();
    g_lvl = '{1'b0, 1'b0};
    g_rem = '{0, 0};
    g_once = '{0, 0};
    g_stuck = '{1'b0, 1'b0};

    // reset state
    run(3);
    chk("rst_lk10", lk10[0], 0);
    chk("rst_er100", er100[0], 0);
    chk("rst_pd10", pd10[0], 0);
    reset = 1'b0;

    // ideal clocks lock both channels
    run(800);
    chk("ideal_pd100", pd100[0], 10);
    chk("ideal_pd10", pd10[0], 100);
    chk("ideal_lk100", lk100[0], 1);
    chk("ideal_lk10", lk10[0], 1);
    chk("ideal_er10", er10[0], 0);

    // 100 kHz stuck low while locked
    g_stuck[1] = 1'b1;
    run(30);
    chk("stuck_er100", er100[0], 1);
    chk("stuck_lk100", lk100[0], 0);
    chk("stuck_lk10", lk10[0], 1);
    chk("stuck_er10", er10[0], 0);
    g_stuck[1] = 1'b0;
    run(40);
    chk("sticky_er100", er100[0], 1);

    // clear coinciding with a detected rise
    found = 1'b0;
    for (int k = 0; k < 30 && !found; k++) begin
      if (m_hist[1][1] && !m_hist[1][2]) found = 1'b1;
      else step(1'b0);
    end
    chk("clr_rise_found", found, 1);
    step(1'b1);
    chk("clr_er100", er100[0], 0);
    chk("clr_lk100", lk100[0], 0);
    chk("clr_lk10", lk10[0], 0);
    run(60);
    chk("relock_lk100", lk100[0], 1);

    // one 11-cycle period in MEASURE after two good periods
    step(1'b1);
    found = 1'b0;
    for (int k = 0; k < 200 && !found; k++) begin
      step(1'b0);
      if (m_st[0][1] == S_MEAS && m_gc[0][1] == 2) found = 1'b1;
    end
    chk("stretch_found", found, 1);
    g_once[1] = 6;
    run(30);
    chk("stretch_er100", er100[0], 0);
    chk("stretch_lk100", lk100[0], 0);
    run(40);
    chk("stretch_relock", lk100[0], 1);

    // 49/51 duty on locked 10 kHz
    run(600);
    chk("duty_pre_lk10", lk10[0], 1);
    g_hi[0] = 49;
    g_lo[0] = 51;
    run(300);
    chk("duty_er10_t0", er10[0], 1);
    chk("duty_lk10_t0", lk10[0], 0);
    chk("duty_lk10_t1", lk10[1], 1);
    chk("duty_er10_t1", er10[1], 0);
    set_ideal();

    // reset in the middle of a 10 kHz period while locked
    step(1'b1);
    run(600);
    found = 1'b0;
    for (int k = 0; k < 200 && !found; k++) begin
      step(1'b0);
      if (!g_lvl[0] && g_rem[0] == 25) found = 1'b1;
    end
    chk("mid_found", found, 1);
    #100;
    reset = 1'b1;
    model_reset();
    #1;
    chk("arst_lk10", lk10[1], 0);
    chk("arst_pd10", pd10[1], 0);
    chk("arst_pd100", pd100[0], 0);
    compare_all();
    run(2);
    reset = 1'b0;
    run(800);
    chk("post_pd10", pd10[0], 100);
    chk("post_pd100", pd100[0], 10);
    chk("post_lk10", lk10[0], 1);
    chk("post_lk100", lk100[0], 1);

    // random near-ideal clocks with jitter and occasional clear
    for (int r = 0; r < 6; r++) begin
      for (int c = 0; c < 2; c++) begin
        g_hi[c] = exp_p[c] / 2 + int'($urandom_range(2)) - 1;
        g_lo[c] = exp_p[c] / 2 + int'($urandom_range(2)) - 1;
        g_jit[c] = int'($urandom_range(1));
      end
      for (int k = 0; k < 500; k++)
        step($urandom_range(299) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
